// File: rtl/hvgen_pkg.sv
// Shared types, default timing and the sync-edge clamp for the video timing generator.
package hvgen_pkg;

  localparam int unsigned DefCw          = 9;
  localparam int unsigned DefRgbw        = 12;
  localparam int unsigned DefHBlkEnd     = 1;
  localparam int unsigned DefHBlkStart   = 290;
  localparam int unsigned DefHSyncStart  = 311;
  localparam int unsigned DefHSyncEnd    = 342;
  localparam int unsigned DefHJumpFrom   = 342;
  localparam int unsigned DefHJumpTo     = 471;
  localparam int unsigned DefHMax        = 511;
  localparam int unsigned DefVBlkStart   = 223;
  localparam int unsigned DefVSyncStart  = 234;
  localparam int unsigned DefVSyncEnd    = 241;
  localparam int unsigned DefVJumpFrom   = 241;
  localparam int unsigned DefVJumpTo     = 491;
  localparam int unsigned DefVMax        = 511;

  typedef logic signed [3:0] ofs_t;

  // Shifted sync edge, kept inside the blanking interval before the jump.
  function automatic int clamp_edge(input int base, input ofs_t ofs, input int lo, input int hi);
    int v;
    v = base + int'(ofs);
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    return v;
  endfunction

endpackage

// File: rtl/hvgen_param_if.sv
// Video timing bundle: core-side inputs and timing/pixel outputs of the generator.
interface hvgen_param_if #(
  parameter int unsigned CW   = 9,
  parameter int unsigned RGBW = 12
);
  logic                CE;
  hvgen_pkg::ofs_t     HOFS;
  hvgen_pkg::ofs_t     VOFS;
  logic [RGBW-1:0]     iRGB;
  logic [CW-1:0]       HPOS;
  logic [CW-1:0]       VPOS;
  logic [RGBW-1:0]     oRGB;
  logic                HBLK;
  logic                VBLK;
  logic                HSYN;
  logic                VSYN;
  logic                DE;
  logic                FRAME_START;
  logic                FIELD;

  modport master (
    output CE, HOFS, VOFS, iRGB,
    input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, FRAME_START, FIELD
  );

  modport slave (
    input  CE, HOFS, VOFS, iRGB,
    output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, FRAME_START, FIELD
  );
endinterface

// File: rtl/hvgen_axis.sv
// One timing axis: counter with jump/wrap, blank flag and offset-adjusted sync flag.
module hvgen_axis import hvgen_pkg::*; #(
  parameter int unsigned CW        = 9,
  parameter bit          HasBlkEnd = 1'b1,
  parameter int unsigned BlkEnd    = 1,
  parameter int unsigned BlkStart  = 290,
  parameter int unsigned SyncStart = 311,
  parameter int unsigned SyncEnd   = 342,
  parameter int unsigned JumpFrom  = 342,
  parameter int unsigned JumpTo    = 471,
  parameter int unsigned Max       = 511
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_step,
  input  ofs_t          i_ofs,
  output logic [CW-1:0] o_cnt,
  output logic          o_blk,
  output logic          o_syn,
  output logic          o_wrap
);

  logic [CW-1:0] r_cnt;
  logic          r_blk;
  logic          r_syn;
  logic [CW-1:0] w_sync_fall;
  logic [CW-1:0] w_sync_rise;

  assign w_sync_fall = CW'(clamp_edge(int'(SyncStart), i_ofs, int'(BlkStart) + 1, int'(JumpFrom)));
  assign w_sync_rise = CW'(clamp_edge(int'(SyncEnd), i_ofs, int'(BlkStart) + 1, int'(JumpFrom)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_blk <= 1'b1;
      r_syn <= 1'b1;
    end else if (i_step) begin
      // Without a blank-end count the blank clears at the wrap instead.
      if (HasBlkEnd && r_cnt == CW'(BlkEnd)) r_blk <= 1'b0;
      if (!HasBlkEnd && r_cnt == CW'(Max)) r_blk <= 1'b0;
      if (r_cnt == CW'(BlkStart)) r_blk <= 1'b1;
      // Rise is applied last so coincident clamped edges give a zero-width pulse.
      if (r_cnt == w_sync_fall) r_syn <= 1'b0;
      if (r_cnt == w_sync_rise) r_syn <= 1'b1;
      if (r_cnt == CW'(JumpFrom)) begin
        r_cnt <= CW'(JumpTo);
      end else if (r_cnt == CW'(Max)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_blk  = r_blk;
  assign o_syn  = r_syn;
  assign o_wrap = i_step && (r_cnt == CW'(Max));

endmodule

// File: rtl/hvgen_param.sv
// Parametrised H/V video timing generator on MCLK with a pixel clock-enable.
module hvgen_param import hvgen_pkg::*; #(
  parameter int unsigned CW           = DefCw,
  parameter int unsigned RGBW         = DefRgbw,
  parameter int unsigned H_BLK_END    = DefHBlkEnd,
  parameter int unsigned H_BLK_START  = DefHBlkStart,
  parameter int unsigned H_SYNC_START = DefHSyncStart,
  parameter int unsigned H_SYNC_END   = DefHSyncEnd,
  parameter int unsigned H_JUMP_FROM  = DefHJumpFrom,
  parameter int unsigned H_JUMP_TO    = DefHJumpTo,
  parameter int unsigned H_MAX        = DefHMax,
  parameter int unsigned V_BLK_START  = DefVBlkStart,
  parameter int unsigned V_SYNC_START = DefVSyncStart,
  parameter int unsigned V_SYNC_END   = DefVSyncEnd,
  parameter int unsigned V_JUMP_FROM  = DefVJumpFrom,
  parameter int unsigned V_JUMP_TO    = DefVJumpTo,
  parameter int unsigned V_MAX        = DefVMax
) (
  input  logic         MCLK,
  input  logic         RESET,
  hvgen_param_if.slave bus
);

  localparam bit HOk = (H_BLK_END < H_BLK_START) && (H_BLK_START < H_SYNC_START) &&
                       (H_SYNC_START <= H_SYNC_END) && (H_SYNC_END <= H_JUMP_FROM) &&
                       (H_JUMP_FROM < H_JUMP_TO) && (H_JUMP_TO <= H_MAX) && ((H_MAX >> CW) == 0);
  localparam bit VOk = (V_BLK_START < V_SYNC_START) && (V_SYNC_START <= V_SYNC_END) &&
                       (V_SYNC_END <= V_JUMP_FROM) && (V_JUMP_FROM < V_JUMP_TO) &&
                       (V_JUMP_TO <= V_MAX) && ((V_MAX >> CW) == 0);

  if (!(HOk && VOk)) begin : g_bad_params
    $error("hvgen_param: illegal timing parameter set");
  end

  ofs_t            r_hofs;
  ofs_t            r_vofs;
  logic [RGBW-1:0] r_rgb;
  logic            r_de;
  logic            r_fs;
  logic            r_field;

  logic [CW-1:0]   w_hcnt;
  logic [CW-1:0]   w_vcnt;
  logic            w_hblk;
  logic            w_vblk;
  logic            w_hsyn;
  logic            w_vsyn;
  logic            w_hwrap;
  logic            w_vwrap;
  logic            w_blank;

  hvgen_axis #(
    .CW        (CW),
    .HasBlkEnd (1'b1),
    .BlkEnd    (H_BLK_END),
    .BlkStart  (H_BLK_START),
    .SyncStart (H_SYNC_START),
    .SyncEnd   (H_SYNC_END),
    .JumpFrom  (H_JUMP_FROM),
    .JumpTo    (H_JUMP_TO),
    .Max       (H_MAX)
  ) u_h_axis (
    .i_clk  (MCLK),
    .i_rst  (RESET),
    .i_step (bus.CE),
    .i_ofs  (r_hofs),
    .o_cnt  (w_hcnt),
    .o_blk  (w_hblk),
    .o_syn  (w_hsyn),
    .o_wrap (w_hwrap)
  );

  hvgen_axis #(
    .CW        (CW),
    .HasBlkEnd (1'b0),
    .BlkEnd    (0),
    .BlkStart  (V_BLK_START),
    .SyncStart (V_SYNC_START),
    .SyncEnd   (V_SYNC_END),
    .JumpFrom  (V_JUMP_FROM),
    .JumpTo    (V_JUMP_TO),
    .Max       (V_MAX)
  ) u_v_axis (
    .i_clk  (MCLK),
    .i_rst  (RESET),
    .i_step (w_hwrap),
    .i_ofs  (r_vofs),
    .o_cnt  (w_vcnt),
    .o_blk  (w_vblk),
    .o_syn  (w_vsyn),
    .o_wrap (w_vwrap)
  );

  assign w_blank = w_hblk | w_vblk;

  // The V wrap strobe already implies CE and the H wrap, so it marks the frame wrap.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_hofs  <= '0;
      r_vofs  <= '0;
      r_rgb   <= '0;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_field <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      if (bus.CE) begin
        r_rgb <= w_blank ? '0 : bus.iRGB;
        r_de  <= ~w_blank;
      end
      if (w_vwrap) begin
        r_fs    <= 1'b1;
        r_field <= ~r_field;
        r_hofs  <= bus.HOFS;
        r_vofs  <= bus.VOFS;
      end
    end
  end

  assign bus.HPOS        = w_hcnt;
  assign bus.VPOS        = w_vcnt;
  assign bus.HBLK        = w_hblk;
  assign bus.VBLK        = w_vblk;
  assign bus.HSYN        = w_hsyn;
  assign bus.VSYN        = w_vsyn;
  assign bus.oRGB        = r_rgb;
  assign bus.DE          = r_de;
  assign bus.FRAME_START = r_fs;
  assign bus.FIELD       = r_field;

endmodule

// File: tb/tb_hvgen_param.sv
// Bench: a shrunk-timing instance against a position-based model, plus a default-timing line.
module tb_hvgen_param;
  import hvgen_pkg::*;

  localparam int unsigned CW = 6, RGBW = 12;
  localparam int HBE = 1, HBS = 20, HSS = 26, HSE = 30, HJF = 32, HJT = 58, HMX = 63;
  localparam int VBS = 10, VSS = 12, VSE = 15, VJF = 16, VJT = 60, VMX = 63;
  localparam int HLEN = (HJF + 1) + (HMX - HJT + 1);
  localparam int VLEN = (VJF + 1) + (VMX - VJT + 1);

  logic mclk = 1'b0;
  logic rst;
  logic drst;
  always #5 mclk = ~mclk;

  hvgen_param_if #(.CW(CW), .RGBW(RGBW)) bus ();
  hvgen_param_if #(.CW(9), .RGBW(12)) dbus ();

  hvgen_param #(
    .CW(CW), .RGBW(RGBW),
    .H_BLK_END(HBE), .H_BLK_START(HBS), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .H_JUMP_FROM(HJF), .H_JUMP_TO(HJT), .H_MAX(HMX),
    .V_BLK_START(VBS), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
    .V_JUMP_FROM(VJF), .V_JUMP_TO(VJT), .V_MAX(VMX)
  ) u_dut (
    .MCLK  (mclk),
    .RESET (rst),
    .bus   (bus)
  );

  hvgen_param u_dut_def (
    .MCLK  (mclk),
    .RESET (drst),
    .bus   (dbus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: raster position index plus the flags derived from it.
  int m_hp, m_vp, m_hofs, m_vofs, m_rgb;
  bit m_first, m_field, m_fs, m_de;

  function automatic int hcnt_of(input int p);
    return (p <= HJF) ? p : p - (HJF + 1) + HJT;
  endfunction

  function automatic int vcnt_of(input int p);
    return (p <= VJF) ? p : p - (VJF + 1) + VJT;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit m_hblk();
    int h = hcnt_of(m_hp);
    return !(h > HBE && h <= HBS);
  endfunction

  function automatic bit m_vblk();
    return m_first || (vcnt_of(m_vp) > VBS);
  endfunction

  function automatic bit m_hsyn();
    int h  = hcnt_of(m_hp);
    int s0 = clampi(HSS + m_hofs, HBS + 1, HJF);
    int s1 = clampi(HSE + m_hofs, HBS + 1, HJF);
    return !(h > s0 && h <= s1);
  endfunction

  function automatic bit m_vsyn();
    int v  = vcnt_of(m_vp);
    int s0 = clampi(VSS + m_vofs, VBS + 1, VJF);
    int s1 = clampi(VSE + m_vofs, VBS + 1, VJF);
    return !(v > s0 && v <= s1);
  endfunction

  task automatic model_reset();
    m_hp = 0; m_vp = 0; m_first = 1'b1; m_hofs = 0; m_vofs = 0;
    m_field = 1'b0; m_fs = 1'b0; m_de = 1'b0; m_rgb = 0;
  endtask

  task automatic model_step(input bit r, input bit ce, input ofs_t ho, input ofs_t vo,
                            input int rgb);
    bit blank;
    if (r) begin
      model_reset();
      return;
    end
    m_fs = 1'b0;
    if (ce) begin
      blank = m_hblk() | m_vblk();
      m_rgb = blank ? 0 : rgb;
      m_de  = !blank;
      if (m_hp == HLEN - 1) begin
        m_hp = 0;
        if (m_vp == VLEN - 1) begin
          m_vp = 0; m_first = 1'b0; m_fs = 1'b1; m_field = !m_field;
          m_hofs = int'(ho); m_vofs = int'(vo);
        end else begin
          m_vp++;
        end
      end else begin
        m_hp++;
      end
    end
  endtask

  task automatic compare_all();
    check("HPOS", 32'(bus.HPOS), 32'(hcnt_of(m_hp)));
    check("VPOS", 32'(bus.VPOS), 32'(vcnt_of(m_vp)));
    check("HBLK", 32'(bus.HBLK), 32'(m_hblk()));
    check("VBLK", 32'(bus.VBLK), 32'(m_vblk()));
    check("HSYN", 32'(bus.HSYN), 32'(m_hsyn()));
    check("VSYN", 32'(bus.VSYN), 32'(m_vsyn()));
    check("oRGB", 32'(bus.oRGB), 32'(m_rgb));
    check("DE", 32'(bus.DE), 32'(m_de));
    check("FRAME_START", 32'(bus.FRAME_START), 32'(m_fs));
    check("FIELD", 32'(bus.FIELD), 32'(m_field));
  endtask

  task automatic cycle(input bit r, input bit ce, input ofs_t ho, input ofs_t vo, input int rgb);
    rst = r; bus.CE = ce; bus.HOFS = ho; bus.VOFS = vo; bus.iRGB = RGBW'(rgb);
    @(posedge mclk);
    model_step(r, ce, ho, vo, rgb);
    #1;
    compare_all();
  endtask

  // Default-timing line measured from a power-on style reset.
  task automatic default_line();
    int hblk_lo, hsyn_lo, first_syn, jumps, zeros, de_hi, prev;
    dbus.CE = 1'b1; dbus.HOFS = '0; dbus.VOFS = '0; dbus.iRGB = 12'hABC;
    drst = 1'b1;
    repeat (3) @(posedge mclk);
    #1;
    check("def_rst_HPOS", 32'(dbus.HPOS), 0);
    check("def_rst_VPOS", 32'(dbus.VPOS), 0);
    check("def_rst_HBLK", 32'(dbus.HBLK), 1);
    check("def_rst_VBLK", 32'(dbus.VBLK), 1);
    check("def_rst_HSYN", 32'(dbus.HSYN), 1);
    check("def_rst_VSYN", 32'(dbus.VSYN), 1);
    check("def_rst_oRGB", 32'(dbus.oRGB), 0);
    check("def_rst_DE", 32'(dbus.DE), 0);
    check("def_rst_FIELD", 32'(dbus.FIELD), 0);
    drst = 1'b0;
    hblk_lo = 0; hsyn_lo = 0; first_syn = -1; jumps = 0; zeros = 0; de_hi = 0; prev = 0;
    for (int k = 1; k <= 384; k++) begin
      @(posedge mclk);
      #1;
      if (!dbus.HBLK) hblk_lo++;
      if (!dbus.HSYN) begin
        hsyn_lo++;
        if (first_syn < 0) first_syn = int'(dbus.HPOS);
      end
      if (prev == 342 && int'(dbus.HPOS) == 471) jumps++;
      if (dbus.HPOS == 9'd0) zeros++;
      if (dbus.DE) de_hi++;
      prev = int'(dbus.HPOS);
    end
    check("def_hblk_low_ces", 32'(hblk_lo), 289);
    check("def_hsyn_low_ces", 32'(hsyn_lo), 31);
    check("def_hsyn_fall_pos", 32'(first_syn), 312);
    check("def_jump_342_471", 32'(jumps), 1);
    check("def_line_period_zeros", 32'(zeros), 1);
    check("def_line_end_HPOS", 32'(dbus.HPOS), 0);
    check("def_line_end_VPOS", 32'(dbus.VPOS), 1);
    check("def_de_first_frame", 32'(de_hi), 0);
  endtask

  initial begin
    rst = 1'b1; bus.CE = 1'b1; bus.HOFS = '0; bus.VOFS = '0; bus.iRGB = '0;
    drst = 1'b1; dbus.CE = 1'b0; dbus.HOFS = '0; dbus.VOFS = '0; dbus.iRGB = '0;
    model_reset();

    repeat (3) cycle(1'b1, 1'b1, 4'sd0, 4'sd0, 0);
    default_line();

    for (int i = 0; i < 10000; i++) begin
      bit   r, ce;
      ofs_t ho, vo;
      int   rgb;
      r   = ($urandom_range(0, 2999) == 0);
      ce  = ($urandom_range(0, 99) < 60);
      ho  = ofs_t'($urandom_range(0, 15));
      vo  = ofs_t'($urandom_range(0, 15));
      rgb = int'($urandom_range(0, 4095));
      // Long CE-low stretch and a reset taken with CE low, mid-frame.
      if (i >= 3000 && i < 3050) ce = 1'b0;
      if (i == 6000) begin
        r = 1'b1;
        ce = 1'b0;
      end
      cycle(r, ce, ho, vo, rgb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hvgen_param.md
Name: hvgen_param

Overview:
- Parametrised successor to the fixed-count arcade video timing generator.
- Runs on the system clock MCLK and advances only on a pixel clock-enable, so it no longer needs a derived pixel clock.
- Adds parametrised H/V counter timing with a jump region, runtime sync-position adjust, a DE output, a frame-start pulse and a field toggle.
- Sits between a game core (consumes HPOS/VPOS, supplies iRGB) and the rotate/scaler video path.

Parameters:
CW, 9, width of HPOS/VPOS counters
RGBW, 12, width of iRGB/oRGB
H_BLK_END, 1, hcnt at which HBLK clears
H_BLK_START, 290, hcnt at which HBLK sets
H_SYNC_START, 311, nominal hcnt at which HSYN falls
H_SYNC_END, 342, nominal hcnt at which HSYN rises
H_JUMP_FROM, 342, hcnt after which counter loads H_JUMP_TO
H_JUMP_TO, 471, hcnt load value for the jump
H_MAX, 511, last hcnt; wraps to 0 and advances vcnt
V_BLK_START, 223, vcnt at which VBLK sets
V_SYNC_START, 234, nominal vcnt at which VSYN falls
V_SYNC_END, 241, nominal vcnt at which VSYN rises
V_JUMP_FROM, 241, vcnt after which counter loads V_JUMP_TO
V_JUMP_TO, 491, vcnt load value for the jump
V_MAX, 511, last vcnt; wraps to 0 and clears VBLK

Ports:
MCLK  in  1  system clock; the only clock
RESET  in  1  synchronous, active-high reset
CE  in  1  pixel clock-enable, one MCLK wide
HOFS  in  4  signed horizontal sync shift, in pixels
VOFS  in  4  signed vertical sync shift, in lines
iRGB  in  RGBW  pixel from the core for the current HPOS/VPOS
HPOS  out  CW  horizontal counter
VPOS  out  CW  vertical counter
oRGB  out  RGBW  blank-gated registered pixel
HBLK  out  1  horizontal blank, active-high
VBLK  out  1  vertical blank, active-high
HSYN  out  1  horizontal sync, active-low
VSYN  out  1  vertical sync, active-low
DE  out  1  ~(HBLK|VBLK), aligned with oRGB
FRAME_START  out  1  one-MCLK pulse at the frame wrap
FIELD  out  1  toggles every frame

Behaviour:
- Clocking: one clock (MCLK); reset is synchronous and active-high (RESET). RESET wins over CE on any edge.
- Reset values: hcnt=vcnt=0, HBLK=VBLK=1, HSYN=VSYN=1, oRGB=0, DE=0, FRAME_START=0, FIELD=0, latched offsets hofs_l=vofs_l=0.
- CE=0: all state holds, except FRAME_START, which is always cleared one MCLK after it was set.
- H step (CE=1), all compares use the pre-edge hcnt:
  - hcnt==H_BLK_END: HBLK<=0.
  - hcnt==H_BLK_START: HBLK<=1.
  - hcnt==HS0: HSYN<=0. HS0 = H_SYNC_START+hofs_l, clamped to [H_BLK_START+1, H_JUMP_FROM].
  - hcnt==HS1: HSYN<=1. HS1 = H_SYNC_END+hofs_l, same clamp.
  - hcnt==H_JUMP_FROM: hcnt<=H_JUMP_TO.
  - hcnt==H_MAX: hcnt<=0 and a V step is taken.
  - Otherwise hcnt<=hcnt+1.
  - Several matches on one count all apply; the jump/wrap load has priority over the +1.
- V step, identical form:
  - vcnt==V_BLK_START: VBLK<=1.
  - vcnt==VS0 / VS1: VSYN fall / rise, with the same ±offset and the same clamp, using vofs_l, V_BLK_START+1 and V_JUMP_FROM.
  - vcnt==V_JUMP_FROM: vcnt<=V_JUMP_TO.
  - vcnt==V_MAX: vcnt<=0, VBLK<=0.
- Frame wrap (CE, hcnt==H_MAX, vcnt==V_MAX):
  - FRAME_START<=1 for one MCLK.
  - FIELD toggles.
  - hofs_l<=HOFS and vofs_l<=VOFS. Offsets never change mid-frame.
- Pixel path (CE=1): oRGB <= (HBLK|VBLK) ? 0 : iRGB, and DE <= ~(HBLK|VBLK), both using pre-edge flags. Latency is 1 CE from iRGB to oRGB.
- Default timing:
  - Line = 384 CEs (counts 0..342, then 471..511).
  - Frame = 263 lines (counts 0..241, then 491..511) = 100992 CEs.
- Clamping can shorten the sync pulse; this is accepted and documented. If HS0 clamps to ≥HS1 (both clamped to H_JUMP_FROM), the sync pulse for that line is zero CEs wide.
- Parameter legality: H_BLK_END < H_BLK_START < H_SYNC_START ≤ H_SYNC_END ≤ H_JUMP_FROM < H_JUMP_TO ≤ H_MAX < 2^CW, and the same ordering for V. Illegal parameter sets are rejected at elaboration.

Decomposition:
- Package hvgen_pkg:
  - default timing constants (the values above);
  - signed offset type (4-bit);
  - clamp function for sync edges.
- Sub-module hvgen_axis, instantiated twice (H and V). It holds:
  - the counter, step enable and jump/wrap logic;
  - blank and sync flags with the offset clamp.
  - Output: a wrap strobe, used as the V step enable and for frame-wrap detection.

Test Plan:
- Reset: assert RESET for 3 MCLK with CE=1 -> HPOS=VPOS=0, HBLK=VBLK=1, HSYN=VSYN=1, oRGB=0, DE=0, FIELD=0.
- Default line: CE every 2nd MCLK, HOFS=VOFS=0 -> HBLK low for 289 CEs per line; HSYN low for 31 CEs (falls after hcnt 311); line period 384 CEs; HPOS sequence 342→471.
- Default frame: run 2 frames -> VBLK low for 224 lines, VSYN low for 7 lines, frame = 100992 CEs, one FRAME_START per frame, FIELD 0→1→0.
- Offsets: HOFS=-4 mid-frame -> no change until the next wrap; then HSYN falls after hcnt 307 and rises after 338. HOFS=+3 -> falls after 314, clamped rise after 342, 28 CEs wide.
- CE gating: hold CE=0 for 50 MCLK mid-line -> all outputs frozen; FRAME_START, if set, clears after 1 MCLK.
- Mid-frame reset: RESET for 1 MCLK at hcnt=200, vcnt=100 with CE=0 -> reset values on the next edge; restart timing identical to a power-on reset.
